// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, opcodes and datapath select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps funct3/funct7[5] to the ALU operation for R- and I-type arithmetic
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] ALUControl
);

    // funct7[5] only selects SUB for register-register ops; immediates have no SUBI
    always_comb begin
        case (funct3)
            3'b000:  ALUControl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ALUControl = ALU_SLL;
            3'b010:  ALUControl = ALU_SLT;
            3'b100:  ALUControl = ALU_XOR;
            3'b101:  ALUControl = ALU_SRL;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore sequencer stepping the shared datapath through fetch/decode/execute/memory/writeback
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WCNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    state_t            state, state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [3:0]        dec_alu;
    logic              limit_hit;
    logic              unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign limit_hit     = wcnt == WCNT_W'(WAIT_LIMIT - 1);

    alu_op_decoder u_alu_op_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7[5]),
        .is_rtype   (state == EXECR),
        .ALUControl (dec_alu)
    );

    // state register; reset lands in FETCH so the same PC is fetched again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // wait counter runs only while a request is outstanding, so any state change or abort clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= '0;
        else        wcnt <= (mem_req && !mem_ready && !mem_timeout) ? wcnt + 1'b1 : '0;
    end

    // next state and Moore outputs; everything is held at 0 while reset is asserted
    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ImmSrc        = IMM_I;
        ALUControl    = ALU_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            ImmSrc = (Op == OP_STORE)  ? IMM_S :
                     (Op == OP_BRANCH) ? IMM_B :
                     (Op == OP_JAL)    ? IMM_J : IMM_I;
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        state_next = DECODE;
                    end else if (limit_hit) begin
                        mem_timeout = 1'b1;
                    end
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    case (Op)
                        OP_LOAD, OP_STORE: state_next = MEMADR;
                        OP_RTYPE:          state_next = EXECR;
                        OP_ITYPE:          state_next = EXECI;
                        OP_BRANCH:         state_next = BEQ;
                        OP_JAL:            state_next = JAL;
                        default: begin
                            illegal_instr = 1'b1;
                            state_next    = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    state_next = (Op == OP_LOAD) ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    if (mem_ready) begin
                        state_next = MEMWB;
                    end else if (limit_hit) begin
                        mem_timeout = 1'b1;
                        state_next  = FETCH;
                    end
                end
                MEMWB: begin
                    ResultSrc  = RES_READDATA;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else if (limit_hit) begin
                        mem_timeout = 1'b1;
                        state_next  = FETCH;
                    end
                end
                EXECR: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUControl = dec_alu;
                    state_next = ALUWB;
                end
                EXECI: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = dec_alu;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                BEQ: begin
                    ALUSrcA    = SRCA_RS1;
                    ALUSrcB    = SRCB_RS2;
                    ALUControl = ALU_SUB;
                    PCWrite    = Zero;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                JAL: begin
                    ALUSrcA    = SRCA_OLDPC;
                    ALUSrcB    = SRCB_FOUR;
                    PCWrite    = 1'b1;
                    state_next = ALUWB;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: per-cycle control-word check against a schedule built from the instruction class rules
module tb_multi_cycle_controller;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] result_src, src_a, src_b, imm_src;
        logic [3:0] alu_ctl;
        logic       done, illegal, timeout;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    logic       instr_done, illegal_instr, mem_timeout;

    ctl_t       got;
    ctl_t       exp_q[$];
    logic       rdy_q[$];
    logic [6:0] p_op = '0;
    logic [6:0] p_f7 = '0;
    logic [2:0] p_f3 = '0;
    logic       p_zero = 1'b0;
    int         errors = 0;
    int         checks = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    logic [6:0] bad_ops [6] = '{7'h7f, 7'h37, 7'h17, 7'h67, 7'h73, 7'h00};
    logic [6:0] good_ops [6] = '{LW, SW, RT, IT, BR, JL};

    always #5 clk = ~clk;

    multi_cycle_controller #(.WAIT_LIMIT(LIMIT), .WCNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Op            (Op),
        .funct3        (funct3),
        .funct7        (funct7),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .MemWrite      (MemWrite),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr),
        .mem_timeout   (mem_timeout)
    );

    assign got = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, instr_done, illegal_instr, mem_timeout};

    task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        return (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic b5, input logic r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
        return (f3 == 3'd0 && r && b5) ? 4'd1 : tbl[f3];
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.imm_src = imm_of(p_op);
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    task automatic push_idle(input ctl_t c);
        push(c, 1'($urandom_range(0, 1)));
    endtask

    task automatic mem_phase(input ctl_t c, input ctl_t ok_c, input int delay, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            ctl_t t;
            if (i == delay) begin
                push(ok_c, 1'b1);
                ok = 1'b1;
                return;
            end
            if (i == LIMIT - 1) begin
                t = c;
                t.timeout = 1'b1;
                push(t, 1'b0);
                return;
            end
            push(c, 1'b0);
        end
    endtask

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input int fd, input int md);
        ctl_t c, k;
        bit ok;
        p_op = op; p_f3 = f3; p_f7 = f7; p_zero = z;
        c = base(); c.mem_req = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10;
        k = c; k.ir_write = 1'b1; k.pc_write = 1'b1;
        mem_phase(c, k, fd, ok);
        if (!ok) mem_phase(c, k, 0, ok);
        c = base(); c.src_a = 2'b01; c.src_b = 2'b01;
        if (!(op inside {LW, SW, RT, IT, BR, JL})) begin
            c.illegal = 1'b1;
            push_idle(c);
            return;
        end
        push_idle(c);
        c = base();
        case (op)
            LW, SW: begin
                c.src_a = 2'b10; c.src_b = 2'b01;
                push_idle(c);
                c = base(); c.mem_req = 1'b1; c.adr_src = 1'b1;
                if (op == LW) begin
                    mem_phase(c, c, md, ok);
                    if (ok) begin
                        c = base(); c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1;
                        push_idle(c);
                    end
                end else begin
                    c.mem_write = 1'b1;
                    k = c; k.done = 1'b1;
                    mem_phase(c, k, md, ok);
                end
                return;
            end
            RT: begin
                c.src_a = 2'b10; c.alu_ctl = alu_of(f3, f7[5], 1'b1);
            end
            IT: begin
                c.src_a = 2'b10; c.src_b = 2'b01; c.alu_ctl = alu_of(f3, f7[5], 1'b0);
            end
            BR: begin
                c.src_a = 2'b10; c.alu_ctl = 4'd1; c.pc_write = z; c.done = 1'b1;
                push_idle(c);
                return;
            end
            default: begin
                c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1;
            end
        endcase
        push_idle(c);
        c = base(); c.reg_write = 1'b1; c.done = 1'b1;
        push_idle(c);
    endtask

    task automatic step(input string tag);
        ctl_t e;
        Op = p_op; funct3 = p_f3; funct7 = p_f7; Zero = p_zero;
        mem_ready = rdy_q.pop_front();
        e = exp_q.pop_front();
        @(negedge clk);
        check(tag, 32'(got), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input int fd, input int md);
        build(op, f3, f7, z, fd, md);
        while (exp_q.size() > 0) step(tag);
    endtask

    initial begin
        ctl_t c;
        logic [6:0] op;
        p_op = SW; Op = SW; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(got), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run("add",        RT, 3'b000, 7'b0000000, 1'b0, 0, 0);
        run("sub",        RT, 3'b000, 7'b0100000, 1'b0, 0, 0);
        run("addi_b5",    IT, 3'b000, 7'b0100000, 1'b0, 0, 0);
        run("and",        RT, 3'b111, 7'b0000000, 1'b0, 0, 0);
        run("r_f3_011",   RT, 3'b011, 7'b0000000, 1'b0, 0, 0);
        run("lw_wait3",   LW, 3'b010, 7'b0000000, 1'b0, 0, 3);
        run("beq_taken",  BR, 3'b000, 7'b0000000, 1'b1, 0, 0);
        run("beq_not",    BR, 3'b000, 7'b0000000, 1'b0, 0, 0);
        run("illegal",    7'h7f, 3'b000, 7'b0000000, 1'b0, 0, 0);
        run("sw_timeout", SW, 3'b010, 7'b0000000, 1'b0, 0, 9);
        run("lw_timeout", LW, 3'b010, 7'b0000000, 1'b0, 0, 4);
        run("fetch_to",   RT, 3'b100, 7'b0000000, 1'b0, 6, 0);
        run("jal",        JL, 3'b000, 7'b0000000, 1'b0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 6) == 0) ? bad_ops[$urandom_range(0, 5)]
                                             : good_ops[$urandom_range(0, 5)];
            run("random", op, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom_range(0, 127)),
                1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5));
        end

        build(SW, 3'b010, 7'b0000000, 1'b0, 0, 10);
        repeat (4) step("sw_pre_reset");
        #1;
        check("mid_memwrite", {31'd0, MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_instr", 32'(got), 32'd0);
        exp_q.delete();
        rdy_q.delete();
        repeat (2) @(negedge clk);
        check("reset_held", 32'(got), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        c = base(); c.mem_req = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10;
        check("fetch_after_reset", 32'(got), 32'(c));
        @(negedge clk);
        check("fetch_after_reset_hold", 32'(got), 32'(c));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Multi-cycle sequencer for the RISC-V core. Replaces single-cycle control with a Moore FSM that steps the shared datapath through fetch, decode, execute, memory and writeback.
- Shares one ALU, one unified memory port and the register file.
- Adds a req/ready memory handshake with a bounded wait.
- Sits between the instruction register / Zero flag and the datapath mux selects and write enables.

Parameters:
- WAIT_LIMIT, 255, max cycles mem_req may stay high without mem_ready before abort. 1..255.
- WCNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]; only bit 5 used
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write qualifier for mem_req
- AdrSrc  out  1  0=PC, 1=ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  4  ALU operation
- instr_done  out  1  one-cycle pulse in the last state of each retired instruction
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse on wait abort

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- State register resets asynchronously to FETCH.
- While rst_n=0 all outputs are 0. Outputs are combinational from state, plus mem_ready/Zero where stated.
- ALUControl defaults to ADD and selects default to 00 unless listed.

State actions and transitions:
- FETCH: mem_req=1, AdrSrc=0, SrcA=PC, SrcB=4, ResultSrc=10.
  - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: SrcA=OldPC, SrcB=imm, ADD (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH with illegal_instr=1 and no writes.
- MEMADR: SrcA=rs1, SrcB=imm, ADD. Go to MEMREAD if Op=lw, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready: instr_done=1, go to FETCH.
- EXECR: SrcA=rs1, SrcB=rs2, ALUControl from sub-decoder. Go to ALUWB.
- EXECI: SrcA=rs1, SrcB=imm, ALUControl from sub-decoder with funct7[5] ignored (no SUBI). Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Go to FETCH.
- BEQ: SrcA=rs1, SrcB=rs2, SUB, ResultSrc=00, PCWrite=Zero, instr_done=1. Go to FETCH.
- JAL: SrcA=OldPC, SrcB=4, ADD, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes rd=OldPC+4.

ImmSrc (combinational from Op):
- sw -> 01, beq -> 10, jal -> 11, all others -> 00.

ALUControl encoding:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL.
- funct3 mapping: 000 ADD (SUB if R-type and funct7[5]), 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND, 011 ADD.

Latency with zero-wait memory:
- beq 3 cycles
- R, I, sw, jal 4 cycles
- lw 5 cycles

Wait counter:
- Clears on every state entry and increments each cycle mem_req=1 && mem_ready=0.
- When it reaches WAIT_LIMIT with mem_ready still 0: mem_timeout=1 that cycle, no enables asserted, next state FETCH.
- A FETCH timeout retries the same PC. A load/store timeout abandons the instruction with no RegWrite.
- mem_ready is ignored when mem_req=0.
- mem_ready on the limit cycle counts as success.

Reset:
- Reset mid-instruction drops all enables immediately. Restart from FETCH after release.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - ALUControl codes
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- One combinational sub-module, alu_op_decoder: inputs funct3, funct7b5, is_rtype; output ALUControl.

Test Plan:
- add x3,x1,x2 (Op=0110011, f3=000, f7=0000000), mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB. ALUControl=0000 in EXECR, RegWrite=1 only in cycle 4, instr_done pulses once.
- sub (f7=0100000) -> ALUControl=0001. addi with f7 bit5=1 -> 0000. R-type f3=111 -> 0010. R-type f3=011 -> 0000.
- lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles, AdrSrc=1. MEMWB has ResultSrc=01, RegWrite=1. Total 8 cycles.
- beq with Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. ALUControl=0001. ImmSrc=10.
- Op=1111111 -> illegal_instr pulse in DECODE, no RegWrite/PCWrite/MemWrite, back in FETCH.
- WAIT_LIMIT=4, sw with mem_ready held 0 -> mem_timeout pulses on the 4th waiting cycle, no instr_done, FETCH next.
- rst_n low mid-MEMWRITE -> all outputs 0 immediately; FETCH with mem_req=1 after release.
